// File: rtl/mdio_mgmt_ctrl_if.sv
// Requester-side bus of the MDIO management master: two request ports
// (port 0 = PHY init sequencer, port 1 = link-status poller) packed into
// shared vectors, plus the grant/done handshake and read result.
`timescale 1ns/1ps
interface mdio_mgmt_ctrl_if;
  logic [1:0]  Req;
  logic [1:0]  Wr;
  logic [9:0]  PhyAddr;
  logic [9:0]  RegAddr;
  logic [31:0] WrData;
  logic [1:0]  Grant;
  logic [1:0]  Done;
  logic [15:0] RdData;
  logic        Busy;

  modport master (
    output Req, Wr, PhyAddr, RegAddr, WrData,
    input  Grant, Done, RdData, Busy
  );

  modport slave (
    input  Req, Wr, PhyAddr, RegAddr, WrData,
    output Grant, Done, RdData, Busy
  );
endinterface

// File: rtl/mdio_mgmt_ctrl.sv
// Clause 22 MDIO management master. Two requesters share one PHY management
// port through a round-robin arbiter; one 64-bit frame is serialised at a
// time. MDC comes from a Clk-enable divider so every MDIO drive (MDC fall)
// and sample (MDC rise) event is a single-cycle strobe in the Clk domain.
// CLK_DIV_CNT must be at least 2.
`timescale 1ns/1ps
module mdio_mgmt_ctrl #(
  parameter int unsigned CLK_DIV_CNT = 50,
  parameter int unsigned GUARD_MDC   = 1
) (
  input  logic            Clk,
  input  logic            Rstn,
  mdio_mgmt_ctrl_if.slave mgmt,
  output logic            MDC,
  output logic            MDIO_O,
  output logic            MDIO_OE,
  input  logic            MDIO_I
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV_CNT);
  localparam int unsigned GRD_W = $clog2(GUARD_MDC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_CNT - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV_CNT - 2);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_MDC - 1);
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  typedef enum logic [1:0] {IDLE, XFER, GUARD} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mdc_q, mdc_d;
  logic [5:0]       bit_q, bit_d;
  logic [63:0]      frame_q, frame_d;
  logic             port_q, port_d;
  logic             wr_q, wr_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [GRD_W-1:0] guard_q, guard_d;
  logic             rr_q, rr_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic [15:0]      rddata_q, rddata_d;
  logic             busy_q, busy_d;
  logic             mdio_o_q, mdio_o_d;
  logic             mdio_oe_q, mdio_oe_d;

  logic             tick, fall_evt, rise_evt, pre_fall;
  logic             win;
  logic [4:0]       phy_sel, reg_sel;
  logic [15:0]      wd_sel;
  logic [63:0]      frame_new;

  assign tick     = (div_q == DIV_LAST);
  assign fall_evt = tick & mdc_q;
  assign rise_evt = tick & ~mdc_q;
  assign pre_fall = mdc_q & (div_q == DIV_PRE);

  // Next-state: divider, arbiter, frame serialiser and guard timer
  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    mdc_d     = tick ? ~mdc_q : mdc_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    port_d    = port_q;
    wr_d      = wr_q;
    shadow_d  = shadow_q;
    guard_d   = guard_q;
    rr_d      = rr_q;
    grant_d   = '0;
    done_d    = '0;
    rddata_d  = rddata_q;
    busy_d    = busy_q;
    mdio_o_d  = mdio_o_q;
    mdio_oe_d = mdio_oe_q;

    // rr_q names the port that wins a tie; a lone requester always wins
    win       = (mgmt.Req == 2'b11) ? rr_q : mgmt.Req[1];
    phy_sel   = win ? mgmt.PhyAddr[9:5] : mgmt.PhyAddr[4:0];
    reg_sel   = win ? mgmt.RegAddr[9:5] : mgmt.RegAddr[4:0];
    wd_sel    = win ? mgmt.WrData[31:16] : mgmt.WrData[15:0];
    frame_new = {32'hFFFF_FFFF, 2'b01, mgmt.Wr[win] ? OP_WR : OP_RD,
                 phy_sel, reg_sel,
                 mgmt.Wr[win] ? 2'b10 : 2'b11,
                 mgmt.Wr[win] ? wd_sel : 16'hFFFF};

    if (rise_evt && state_q == XFER && !wr_q && bit_q >= 6'd48)
      shadow_d = {shadow_q[14:0], MDIO_I};

    case (state_q)
      IDLE: begin
        if (fall_evt && (mgmt.Req != 2'b00)) begin
          grant_d   = win ? 2'b10 : 2'b01;
          rr_d      = ~win;
          port_d    = win;
          wr_d      = mgmt.Wr[win];
          mdio_o_d  = frame_new[63];
          frame_d   = {frame_new[62:0], 1'b0};
          mdio_oe_d = 1'b1;
          busy_d    = 1'b1;
          bit_d     = '0;
          state_d   = XFER;
        end
      end
      XFER: begin
        if (fall_evt) begin
          if (bit_q == 6'd63) begin
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
            done_d    = port_q ? 2'b10 : 2'b01;
            if (!wr_q)
              rddata_d = shadow_q;
            guard_d   = '0;
            state_d   = GUARD;
          end else begin
            bit_d     = bit_q + 6'd1;
            mdio_o_d  = frame_q[63];
            frame_d   = {frame_q[62:0], 1'b0};
            mdio_oe_d = wr_q | (bit_q < 6'd45);
          end
        end
      end
      GUARD: begin
        // Leave one Clk before the closing fall event so IDLE can grant on
        // that very fall while Busy still shows a low cycle between frames.
        if (fall_evt)
          guard_d = guard_q + 1'b1;
        else if (pre_fall && guard_q == GRD_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      state_q   <= IDLE;
      div_q     <= '0;
      mdc_q     <= 1'b1;
      bit_q     <= '0;
      frame_q   <= '0;
      port_q    <= 1'b0;
      wr_q      <= 1'b0;
      shadow_q  <= '0;
      guard_q   <= '0;
      rr_q      <= 1'b0;
      grant_q   <= '0;
      done_q    <= '0;
      rddata_q  <= '0;
      busy_q    <= 1'b0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      mdc_q     <= mdc_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      port_q    <= port_d;
      wr_q      <= wr_d;
      shadow_q  <= shadow_d;
      guard_q   <= guard_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      rddata_q  <= rddata_d;
      busy_q    <= busy_d;
      mdio_o_q  <= mdio_o_d;
      mdio_oe_q <= mdio_oe_d;
    end
  end

  assign mgmt.Grant  = grant_q;
  assign mgmt.Done   = done_q;
  assign mgmt.RdData = rddata_q;
  assign mgmt.Busy   = busy_q;
  assign MDC         = mdc_q;
  assign MDIO_O      = mdio_o_q;
  assign MDIO_OE     = mdio_oe_q;

endmodule

// File: tb/tb_mdio_mgmt_ctrl.sv
// Bench for mdio_mgmt_ctrl: MDC waveform from cycle arithmetic, expected
// frames assembled field by field, a PHY that answers reads with random data,
// and a round-robin model kept as "last port served".
`timescale 1ns/1ps
module tb_mdio_mgmt_ctrl;
  localparam int DIV = 4;
  localparam int GRD = 1;
  localparam int PER = 2 * DIV;
  localparam int GRANT_LIMIT = (GRD + 1) * PER + 4;

  logic Clk = 1'b0;
  logic Rstn = 1'b0;
  logic MDC, MDIO_O, MDIO_OE;
  logic MDIO_I = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  bit mdc_chk_en = 1'b0;
  int last_port = 1;
  logic [15:0] last_rd = '0;

  logic        cfg_wr [2];
  logic [4:0]  cfg_phy [2];
  logic [4:0]  cfg_reg [2];
  logic [15:0] cfg_wd [2];
  logic [15:0] cfg_rd [2];

  mdio_mgmt_ctrl_if bus ();

  mdio_mgmt_ctrl #(.CLK_DIV_CNT(DIV), .GUARD_MDC(GRD)) dut (
    .Clk(Clk), .Rstn(Rstn), .mgmt(bus),
    .MDC(MDC), .MDIO_O(MDIO_O), .MDIO_OE(MDIO_OE), .MDIO_I(MDIO_I)
  );

  always #5 Clk = ~Clk;

  // Clk edges since the last reset edge
  always @(posedge Clk) t <= Rstn ? t + 1 : 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // MDC is high for DIV cycles after reset, then alternates every DIV cycles
  always begin
    @(posedge Clk);
    #1;
    if (mdc_chk_en) chk("mdc", MDC, ((t / DIV) % 2 == 0) ? 1 : 0);
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_cfg(input int p, input logic wr, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [15:0] wd, input logic [15:0] rd);
    cfg_wr[p] = wr; cfg_phy[p] = phy; cfg_reg[p] = rg; cfg_wd[p] = wd; cfg_rd[p] = rd;
    bus.Wr[p] = wr;
    bus.PhyAddr[p*5 +: 5] = phy;
    bus.RegAddr[p*5 +: 5] = rg;
    bus.WrData[p*16 +: 16] = wd;
  endtask

  task automatic do_reset();
    bus.Req = '0;
    Rstn = 1'b0;
    cyc(); cyc();
    Rstn = 1'b1;
    last_port = 1;
    last_rd = '0;
  endtask

  task automatic wait_grant(input logic [1:0] exp, output int waited, output int busy_low);
    waited = 0;
    busy_low = 0;
    while (bus.Grant == 2'b00 && waited < GRANT_LIMIT) begin
      if (!bus.Busy) busy_low++;
      cyc();
      waited++;
    end
    chk("grant", bus.Grant, exp);
  endtask

  // Called on the Grant sample; ends on the sample where Done must appear
  task automatic run_frame(input int p);
    logic [63:0] exp_f, exp_oe, got_f, got_oe;
    logic [15:0] rd;
    int early, b;
    rd = cfg_rd[p];
    exp_f = {32'hFFFF_FFFF, 2'b01, cfg_wr[p] ? 2'b01 : 2'b10,
             cfg_phy[p], cfg_reg[p], 2'b10, cfg_wd[p]};
    exp_oe = cfg_wr[p] ? '1 : {{46{1'b1}}, 18'd0};
    got_f = '0; got_oe = '0; early = 0;
    chk("grant_on_fall", t % PER, DIV);
    chk("busy_at_grant", bus.Busy, 1);
    for (int k = 0; k < 64 * PER; k++) begin
      b = k / PER;
      if (k % PER == 0) begin
        got_f[63-b] = MDIO_O;
        got_oe[63-b] = MDIO_OE;
        if (cfg_wr[p]) MDIO_I = 1'b1;
        else if (b >= 48) MDIO_I = rd[63-b];
        else if (b == 47) MDIO_I = 1'b0;
        else MDIO_I = 1'b1;
      end
      if (bus.Done != 2'b00) early++;
      cyc();
    end
    chk("frame_bits", got_f & exp_oe, exp_f & exp_oe);
    chk("frame_oe", got_oe, exp_oe);
    chk("early_done", early, 0);
    chk("done", bus.Done, (p == 1) ? 2'b10 : 2'b01);
    chk("oe_after", MDIO_OE, 0);
    chk("o_after", MDIO_O, 1);
    if (!cfg_wr[p]) last_rd = rd;
    chk("rddata", bus.RdData, last_rd);
    MDIO_I = 1'b1;
  endtask

  task automatic single(input int p, input int delay);
    int waited, busy_low;
    repeat (delay) cyc();
    bus.Req[p] = 1'b1;
    wait_grant((p == 1) ? 2'b10 : 2'b01, waited, busy_low);
    bus.Req[p] = 1'b0;
    last_port = p;
    run_frame(p);
  endtask

  initial begin
    int cnt, waited, busy_low, exp_p, n;
    bus.Req = '0; bus.Wr = '0; bus.PhyAddr = '0; bus.RegAddr = '0; bus.WrData = '0;

    // Reset values
    Rstn = 1'b0;
    cyc(); cyc();
    chk("rst_mdc", MDC, 1);
    chk("rst_mdio_o", MDIO_O, 1);
    chk("rst_oe", MDIO_OE, 0);
    chk("rst_grant", bus.Grant, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_rddata", bus.RdData, 0);
    chk("rst_busy", bus.Busy, 0);
    mdc_chk_en = 1'b1;
    Rstn = 1'b1;

    // Idle divider run
    cnt = 0;
    repeat (3 * PER) begin
      if (MDIO_OE || bus.Busy) cnt++;
      cyc();
    end
    chk("idle_quiet", cnt, 0);

    // Directed write, read, then write that must leave RdData alone
    set_cfg(0, 1'b1, 5'd1, 5'd0, 16'h1140, 16'h0000);
    single(0, 0);
    set_cfg(1, 1'b0, 5'd1, 5'd1, 16'h0000, 16'h796D);
    single(1, 0);
    set_cfg(0, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0000);
    single(0, 3);

    // Short Req pulse between fall events is dropped
    n = 0;
    while (!(bus.Busy == 1'b0 && t % PER == DIV) && n < 4 * PER) begin
      cyc();
      n++;
    end
    bus.Req[1] = 1'b1;
    cyc(); cyc();
    bus.Req[1] = 1'b0;
    cnt = 0;
    repeat (3 * PER) begin
      if (bus.Grant != 2'b00 || bus.Busy) cnt++;
      cyc();
    end
    chk("pulse_ignored", cnt, 0);

    // Both ports requesting continuously from reset
    do_reset();
    set_cfg(0, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
    set_cfg(1, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
    bus.Req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_p = 1 - last_port;
      wait_grant((exp_p == 1) ? 2'b10 : 2'b01, waited, busy_low);
      if (i > 0) begin
        chk("rr_gap", waited, GRD * PER);
        chk("rr_busy_low", (busy_low >= 1) ? 1 : 0, 1);
      end
      last_port = exp_p;
      run_frame(exp_p);
    end
    bus.Req = '0;

    // Reset during bit 40 of a port0 write
    set_cfg(0, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0000);
    bus.Req[0] = 1'b1;
    wait_grant(2'b01, waited, busy_low);
    bus.Req[0] = 1'b0;
    repeat (40 * PER + 3) cyc();
    Rstn = 1'b0;
    cyc();
    chk("abort_mdc", MDC, 1);
    chk("abort_oe", MDIO_OE, 0);
    chk("abort_o", MDIO_O, 1);
    chk("abort_busy", bus.Busy, 0);
    chk("abort_done", bus.Done, 0);
    chk("abort_rddata", bus.RdData, 0);
    Rstn = 1'b1;
    last_port = 1;
    last_rd = '0;
    cnt = 0;
    repeat (3 * PER) begin
      if (bus.Done != 2'b00 || MDIO_OE || bus.Grant != 2'b00) cnt++;
      cyc();
    end
    chk("abort_quiet", cnt, 0);
    single(0, 1);

    // Randomised single-port traffic
    for (int i = 0; i < 10; i++) begin
      exp_p = int'($urandom_range(0, 1));
      set_cfg(exp_p, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
      single(exp_p, int'($urandom_range(0, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
